uart_vol_frame_parser: RTL and testbench

Framed UART command decoder that sits upstream of the WM8960 I2C init/control stage. Consumes bytes from the UART byte receiver and validates 4-byte frames (header, command, argument, checksum). Maintains the 4-bit volume/level index and issues a single-cycle `go` to restart the codec register-write sequence, deferring it while a sequence is still running. Replaces the bare byte-to-level mapping with checksummed, timeout-protected commands.

---
 rtl/uart_cmd_pkg.sv | 13 +
 rtl/uart_vol_frame_parser_if.sv | 15 +
 rtl/frame_timeout_timer.sv | 21 ++
 rtl/uart_vol_frame_parser.sv | 103 ++++++++++
 tb/tb_uart_vol_frame_parser.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared FSM state type, command codes and frame header for the UART volume parser.
package uart_cmd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_CHK, S_EXEC} state_t;
  localparam logic [7:0] DEF_HEADER  = 8'hAA;
  localparam logic [7:0] CMD_SET     = 8'h01;
  localparam logic [7:0] CMD_UP      = 8'h02;
  localparam logic [7:0] CMD_DOWN    = 8'h03;
  localparam logic [7:0] CMD_MUTE    = 8'h04;
  localparam logic [7:0] CMD_REFRESH = 8'h05;
  function automatic logic [7:0] frame_sum(input logic [7:0] h, input logic [7:0] c, input logic [7:0] a);
    return h + c + a;
  endfunction
endpackage

// File: rtl/uart_vol_frame_parser_if.sv
// uart_vol_frame_parser_if: byte-receiver inputs, sequencer busy and level/go/error outputs.
// slave: parser side (rx_data, rx_done, seq_busy in; level, level_upd, go, frame_err, err_cnt out).
// master: driver/observer side, directions mirrored.
interface uart_vol_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       seq_busy;
  logic [3:0] level;
  logic       level_upd;
  logic       go;
  logic       frame_err;
  logic [7:0] err_cnt;
  modport slave (input rx_data, rx_done, seq_busy, output level, level_upd, go, frame_err, err_cnt);
  modport master (output rx_data, rx_done, seq_busy, input level, level_upd, go, frame_err, err_cnt);
endinterface

// File: rtl/frame_timeout_timer.sv
// frame_timeout_timer: inter-byte timer; clr_i zeroes, en_i counts, expire_o flags the TIMEOUT_CYC-1 count.
// Ports: Clk, Rst_n (async active-low), clr_i, en_i in; expire_o out.
module frame_timeout_timer #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  // A byte arriving on the expiry cycle wins, so clear masks expiry.
  assign expire_o = en_i & ~clr_i & (cnt_q == LAST);
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_vol_frame_parser.sv
// uart_vol_frame_parser: validates AA/cmd/arg/checksum frames, tracks the level and arbitrates go.
// Ports: Clk, Rst_n (async active-low), bus (slave modport of uart_vol_frame_parser_if).
module uart_vol_frame_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] HEADER      = DEF_HEADER,
  parameter logic [3:0] MAX_LEVEL   = 4'd11,
  parameter logic [3:0] RESET_LEVEL = 4'd5,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input logic Clk,
  input logic Rst_n,
  uart_vol_frame_parser_if.slave bus
);
  state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d, arg_q, arg_d, err_cnt_q, err_cnt_d;
  logic [3:0] level_q, level_d, exec_lvl;
  logic upd_q, upd_d, go_q, go_d, err_q, err_d, pend_q, pend_d;
  logic exec, exec_err, expire, in_frame;
  assign in_frame = state_q inside {S_CMD, S_ARG, S_CHK};
  assign exec = state_q == S_EXEC;
  frame_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .Clk(Clk), .Rst_n(Rst_n), .clr_i(bus.rx_done | (state_q == S_IDLE)), .en_i(in_frame), .expire_o(expire)
  );
  always_comb begin
    exec_lvl = level_q;
    exec_err = 1'b0;
    case (cmd_q)
      CMD_SET: begin
        exec_err = arg_q > {4'd0, MAX_LEVEL};
        exec_lvl = exec_err ? level_q : arg_q[3:0];
      end
      CMD_UP:      exec_lvl = (level_q >= MAX_LEVEL) ? MAX_LEVEL : level_q + 4'd1;
      CMD_DOWN:    exec_lvl = (level_q == 4'd0) ? 4'd0 : level_q - 4'd1;
      CMD_MUTE:    exec_lvl = 4'd0;
      CMD_REFRESH: exec_lvl = level_q;
      default:     exec_err = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    arg_d = arg_q;
    err_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = (bus.rx_done && bus.rx_data == HEADER) ? S_CMD : S_IDLE;
      S_CMD: if (bus.rx_done) begin
        cmd_d = bus.rx_data;
        state_d = S_ARG;
      end
      S_ARG: if (bus.rx_done) begin
        arg_d = bus.rx_data;
        state_d = S_CHK;
      end
      S_CHK: if (bus.rx_done) begin
        err_d = bus.rx_data != frame_sum(HEADER, cmd_q, arg_q);
        state_d = err_d ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        err_d = exec_err;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (expire) begin
      state_d = S_IDLE;
      err_d = 1'b1;
    end
    level_d = exec ? exec_lvl : level_q;
    upd_d = exec && exec_lvl != level_q;
    // Setting has priority over the go-clear so an update landing with go still earns its own go.
    pend_d = upd_d | (exec && cmd_q == CMD_REFRESH) | (pend_q & bus.seq_busy);
    go_d = pend_q & ~bus.seq_busy;
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cmd_q <= '0;
      arg_q <= '0;
      level_q <= RESET_LEVEL;
      upd_q <= 1'b0;
      go_q <= 1'b0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      arg_q <= arg_d;
      level_q <= level_d;
      upd_q <= upd_d;
      go_q <= go_d;
      err_q <= err_d;
      pend_q <= pend_d;
      err_cnt_q <= err_cnt_d;
    end
  assign bus.level = level_q;
  assign bus.level_upd = upd_q;
  assign bus.go = go_q;
  assign bus.frame_err = err_q;
  assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_uart_vol_frame_parser.sv
// tb_uart_vol_frame_parser: directed frames with hand-computed checksums and expected level/pulse counts.
module tb_uart_vol_frame_parser;
  localparam int TO = 40;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  uart_vol_frame_parser_if bus();
  uart_vol_frame_parser #(.TIMEOUT_CYC(TO)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  always #5 Clk = ~Clk;
  int cyc = 0, n_chk = 0, n_err = 0;
  int n_go = 0, n_upd = 0, n_fe = 0, go_cyc = -1, fe_cyc = -1;
  int b_go, b_upd, b_fe, c;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk)
    if (Rst_n) begin
      if (bus.go) begin
        n_go <= n_go + 1;
        go_cyc <= cyc;
      end
      if (bus.level_upd) n_upd <= n_upd + 1;
      if (bus.frame_err) begin
        n_fe <= n_fe + 1;
        fe_cyc <= cyc;
      end
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    @(posedge Clk);
    #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge Clk);
    #1;
    bus.rx_done = 1'b0;
  endtask
  task automatic frame(input logic [7:0] cm, input logic [7:0] ar, input logic [7:0] sm);
    send(8'hAA);
    send(cm);
    send(ar);
    send(sm);
  endtask
  task automatic mark();
    b_go = n_go;
    b_upd = n_upd;
    b_fe = n_fe;
  endtask
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.seq_busy = 1'b0;
    tick(3);
    check("rst_level", bus.level, 5);
    check("rst_upd", bus.level_upd, 0);
    check("rst_go", bus.go, 0);
    check("rst_fe", bus.frame_err, 0);
    check("rst_errcnt", bus.err_cnt, 0);
    Rst_n = 1'b1;
    tick(2);
    mark();
    frame(8'h01, 8'h07, 8'hB2);
    c = cyc;
    tick(6);
    check("set7_level", bus.level, 7);
    check("set7_upd", n_upd - b_upd, 1);
    check("set7_go", n_go - b_go, 1);
    check("set7_go_lat", go_cyc - c, 2);
    check("set7_noerr", n_fe - b_fe, 0);
    mark();
    frame(8'h01, 8'h03, 8'h00);
    check("badchk_fe_n1", bus.frame_err, 1);
    tick(6);
    check("badchk_level", bus.level, 7);
    check("badchk_errcnt", bus.err_cnt, 1);
    check("badchk_go", n_go - b_go, 0);
    mark();
    send(8'hAA);
    send(8'h01);
    c = cyc;
    tick(TO + 4);
    check("to_fe", n_fe - b_fe, 1);
    check("to_lat", fe_cyc - c, TO);
    check("to_errcnt", bus.err_cnt, 2);
    frame(8'h01, 8'h04, 8'hAF);
    tick(4);
    check("after_to_level", bus.level, 4);
    frame(8'h01, 8'h0B, 8'hB6);
    tick(6);
    check("set11_level", bus.level, 11);
    mark();
    frame(8'h02, 8'h00, 8'hAC);
    tick(6);
    check("up_sat_level", bus.level, 11);
    check("up_sat_upd", n_upd - b_upd, 0);
    check("up_sat_go", n_go - b_go, 0);
    frame(8'h04, 8'h00, 8'hAE);
    tick(6);
    mark();
    frame(8'h03, 8'h00, 8'hAD);
    tick(6);
    check("dn_sat_level", bus.level, 0);
    check("dn_sat_upd", n_upd - b_upd, 0);
    check("dn_sat_go", n_go - b_go, 0);
    bus.seq_busy = 1'b1;
    mark();
    frame(8'h01, 8'h03, 8'hAE);
    frame(8'h01, 8'h04, 8'hAF);
    frame(8'h01, 8'h09, 8'hB4);
    tick(10);
    check("busy_level", bus.level, 9);
    check("busy_upd", n_upd - b_upd, 3);
    check("busy_go_held", n_go - b_go, 0);
    c = cyc;
    bus.seq_busy = 1'b0;
    tick(6);
    check("busy_go_one", n_go - b_go, 1);
    check("busy_go_lat", go_cyc - c, 1);
    mark();
    send(8'h12);
    send(8'h34);
    frame(8'h04, 8'h00, 8'hAE);
    tick(4);
    check("stray_level", bus.level, 0);
    check("stray_noerr", n_fe - b_fe, 0);
    mark();
    frame(8'h01, 8'h0C, 8'hB7);
    tick(4);
    check("setbig_level", bus.level, 0);
    check("setbig_fe", n_fe - b_fe, 1);
    check("setbig_errcnt", bus.err_cnt, 3);
    mark();
    frame(8'h05, 8'h00, 8'hAF);
    tick(6);
    check("refresh_go", n_go - b_go, 1);
    check("refresh_upd", n_upd - b_upd, 0);
    frame(8'h06, 8'h00, 8'hB0);
    tick(4);
    check("badcmd_errcnt", bus.err_cnt, 4);
    send(8'hAA);
    send(8'h01);
    Rst_n = 1'b0;
    #1;
    check("midrst_level", bus.level, 5);
    check("midrst_errcnt", bus.err_cnt, 0);
    tick(2);
    Rst_n = 1'b1;
    frame(8'h01, 8'h02, 8'hAD);
    tick(4);
    check("postrst_level", bus.level, 2);
    repeat (260) frame(8'h01, 8'h00, 8'h00);
    tick(4);
    check("errcnt_sat", bus.err_cnt, 255);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
